// File: rtl/game_ctrl.sv
// Tic-tac-toe game controller: sequences player and AI moves on a 3x3 board,
// detects wins and draws, and forces a fallback AI move on timeout or an illegal AI move.
module game_ctrl #(
  parameter int unsigned AI_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        new_game,
  input  logic        player_valid,
  input  logic [3:0]  player_pos,
  input  logic [3:0]  ai_tick,
  input  logic        ai_done,
  output logic [17:0] cell_position,
  output logic        ai_start,
  output logic        player_ready,
  output logic        illegal_move,
  output logic        ai_error,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic [3:0]  move_count
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] TO_LAST = CW'(AI_TIMEOUT - 1);
  localparam logic [1:0] MARK_NONE = 2'b00;
  localparam logic [1:0] MARK_P    = 2'b01;
  localparam logic [1:0] MARK_AI   = 2'b10;
  localparam logic [1:0] MARK_DRAW = 2'b11;

  typedef enum logic [2:0] {
    WAIT_PLAYER = 3'd0,
    CHECK_P     = 3'd1,
    AI_START    = 3'd2,
    AI_WAIT     = 3'd3,
    CHECK_AI    = 3'd4,
    GAME_OVER   = 3'd5
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  // Indices >= 9 read as empty; callers range-check separately.
  function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] idx);
    logic [1:0] v;
    v = MARK_NONE;
    for (int k = 0; k < 9; k++)
      if (idx == 4'(k)) v = b[2*k +: 2];
    return v;
  endfunction

  function automatic logic [17:0] set_cell(input logic [17:0] b, input logic [3:0] idx,
                                           input logic [1:0] m);
    logic [17:0] r;
    r = b;
    for (int k = 0; k < 9; k++)
      if (idx == 4'(k)) r[2*k +: 2] = m;
    return r;
  endfunction

  function automatic logic [3:0] lowest_empty(input logic [17:0] b);
    logic [3:0] r;
    r = 4'd0;
    for (int k = 8; k >= 0; k--)
      if (b[2*k +: 2] == MARK_NONE) r = 4'(k);
    return r;
  endfunction

  function automatic logic has_line(input logic [17:0] b, input logic [1:0] m);
    logic [8:0] h;
    for (int k = 0; k < 9; k++) h[k] = (b[2*k +: 2] == m);
    return (h[0] & h[1] & h[2]) | (h[3] & h[4] & h[5]) | (h[6] & h[7] & h[8]) |
           (h[0] & h[3] & h[6]) | (h[1] & h[4] & h[7]) | (h[2] & h[5] & h[8]) |
           (h[0] & h[4] & h[8]) | (h[2] & h[4] & h[6]);
  endfunction

  logic       player_ok;
  logic       ai_ok;
  logic [3:0] free_idx;
  logic       win_p;
  logic       win_ai;

  assign player_ok = (player_pos < 4'd9) && (cell_at(cell_position, player_pos) == MARK_NONE);
  assign ai_ok     = (ai_tick < 4'd9) && (cell_at(cell_position, ai_tick) == MARK_NONE);
  assign free_idx  = lowest_empty(cell_position);
  assign win_p     = has_line(cell_position, MARK_P);
  assign win_ai    = has_line(cell_position, MARK_AI);

  // Game sequencer; pulse outputs default low each cycle, new_game overrides everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= WAIT_PLAYER;
      cnt           <= '0;
      cell_position <= '0;
      move_count    <= '0;
      winner        <= MARK_NONE;
      ai_start      <= 1'b0;
      illegal_move  <= 1'b0;
      ai_error      <= 1'b0;
      game_over     <= 1'b0;
      player_ready  <= 1'b1;
    end else begin
      ai_start     <= 1'b0;
      illegal_move <= 1'b0;
      ai_error     <= 1'b0;
      if (new_game) begin
        state         <= WAIT_PLAYER;
        cnt           <= '0;
        cell_position <= '0;
        move_count    <= '0;
        winner        <= MARK_NONE;
        game_over     <= 1'b0;
        player_ready  <= 1'b1;
      end else begin
        case (state)
          WAIT_PLAYER: begin
            if (player_valid) begin
              if (player_ok) begin
                cell_position <= set_cell(cell_position, player_pos, MARK_P);
                move_count    <= move_count + 4'd1;
                player_ready  <= 1'b0;
                state         <= CHECK_P;
              end else begin
                illegal_move <= 1'b1;
              end
            end
          end
          CHECK_P: begin
            if (win_p) begin
              winner    <= MARK_P;
              game_over <= 1'b1;
              state     <= GAME_OVER;
            end else if (move_count == 4'd9) begin
              winner    <= MARK_DRAW;
              game_over <= 1'b1;
              state     <= GAME_OVER;
            end else begin
              ai_start <= 1'b1;
              state    <= AI_START;
            end
          end
          AI_START: begin
            cnt   <= '0;
            state <= AI_WAIT;
          end
          AI_WAIT: begin
            if (ai_done && ai_ok) begin
              cell_position <= set_cell(cell_position, ai_tick, MARK_AI);
              move_count    <= move_count + 4'd1;
              state         <= CHECK_AI;
            end else if (ai_done || (cnt == TO_LAST)) begin
              // An empty cell always exists here since CHECK_P saw fewer than 9 moves.
              ai_error      <= 1'b1;
              cell_position <= set_cell(cell_position, free_idx, MARK_AI);
              move_count    <= move_count + 4'd1;
              state         <= CHECK_AI;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          CHECK_AI: begin
            if (win_ai) begin
              winner    <= MARK_AI;
              game_over <= 1'b1;
              state     <= GAME_OVER;
            end else if (move_count == 4'd9) begin
              winner    <= MARK_DRAW;
              game_over <= 1'b1;
              state     <= GAME_OVER;
            end else begin
              player_ready <= 1'b1;
              state        <= WAIT_PLAYER;
            end
          end
          GAME_OVER: begin
            game_over <= 1'b1;
          end
          default: begin
            player_ready <= 1'b1;
            state        <= WAIT_PLAYER;
          end
        endcase
      end
    end
  end

endmodule
